skew_seq: RTL and testbench

SKEW_SEQ -- requirements
Module: skew_seq

---
 rtl/skew_seq.sv | 137 +++++++++++++
 tb/tb_skew_seq.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/skew_seq.sv
// Diagonal-skew shift-enable sequencer for DIM row delay buffers.
// Define SKEW_SEQ_PERF_EN to build the busy-cycle performance counter.
module skew_seq #(
  parameter int DIM   = 8,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + DIM)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           stall,
  output logic [DIM-1:0] en,
  output logic           zero_in,
  output logic [CW-1:0]  src_idx,
  output logic           busy,
  output logic           done,
  output logic [31:0]    perf_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN
  } state_e;

  localparam logic [CW-1:0] STREAM_LAST = CW'(DEPTH + DIM - 2);
  localparam logic [CW-1:0] DRAIN_LAST  = CW'(DEPTH - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_STREAM;
          cnt_d   = '0;
        end
      end
      S_STREAM: begin
        if (!stall) begin
          if (cnt_q == STREAM_LAST) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!stall) begin
          if (cnt_q == DRAIN_LAST) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Row i is live for the DEPTH phases starting at phase i.
  always_comb begin
    en      = '0;
    zero_in = 1'b0;
    src_idx = '0;
    unique case (state_q)
      S_STREAM: begin
        src_idx = cnt_q;
        for (int i = 0; i < DIM; i++) begin
          en[i] = !stall
                  && (int'(cnt_q) >= i)
                  && (int'(cnt_q) < i + DEPTH);
        end
      end
      S_DRAIN: begin
        src_idx = cnt_q;
        zero_in = 1'b1;
        en      = stall ? '0 : '1;
      end
      default: begin
        en = '0;
      end
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;

`ifdef SKEW_SEQ_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (state_q == S_IDLE && start) begin
      perf_d = '0;
    end else if (busy && perf_q != 32'hFFFF_FFFF) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cnt = perf_q;
`else
  assign perf_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_skew_seq.sv
// Directed bench for skew_seq (DIM=8, DEPTH=8).
// Cycle 0 is the cycle in which start is driven.
module tb_skew_seq;

`ifdef SKEW_SEQ_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stall;
  logic [7:0] en;
  logic       zero_in;
  logic [3:0] src_idx;
  logic       busy;
  logic       done;
  logic [31:0] perf_cnt;

  int total;
  int bad;

  logic [7:0]  en_h [64];
  logic [3:0]  ix_h [64];
  logic        zi_h [64];
  logic        bu_h [64];
  logic        dn_h [64];
  logic [31:0] pf_h [64];
  int          rows [8];
  int          done_cyc;
  int          ndone;

  skew_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stall    (stall),
    .en       (en),
    .zero_in  (zero_in),
    .src_idx  (src_idx),
    .busy     (busy),
    .done     (done),
    .perf_cnt (perf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Drives one sequence and records per-cycle outputs; bounded at 60 cycles.
  task automatic run_seq(input int sf, input int sl,
                         input int s2a, input int s2b);
    for (int r = 0; r < 8; r++) rows[r] = 0;
    done_cyc = -1;
    ndone    = 0;
    for (int c = 0; c < 60; c++) begin
      start = (c == 0) || (c == s2a) || (c == s2b);
      stall = (c >= sf) && (c < sf + sl);
      #1;
      en_h[c] = en;
      ix_h[c] = src_idx;
      zi_h[c] = zero_in;
      bu_h[c] = busy;
      dn_h[c] = done;
      pf_h[c] = perf_cnt;
      for (int r = 0; r < 8; r++) rows[r] += int'(en[r]);
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
      tick();
    end
    start = 1'b0;
    stall = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b1;
    stall = 1'b0;
    #3;
    total++;
    if ({en, zero_in, src_idx, busy, done} !== 15'd0 || perf_cnt !== 32'd0) begin
      bad++;
      $display("FAIL reset_outs got=%h/%h exp=0",
               {en, zero_in, src_idx, busy, done}, perf_cnt);
    end
    tick();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_hold_busy got=%b exp=0", busy);
    end
    start = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_run;
    logic [7:0] exp_en [15];
    exp_en = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
               8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80};
    run_seq(100, 0, -9, -9);
    total++;
    if (bu_h[0] !== 1'b0 || bu_h[1] !== 1'b1) begin
      bad++;
      $display("FAIL single_busy_rise got=%b%b exp=01", bu_h[0], bu_h[1]);
    end
    for (int k = 0; k < 15; k++) begin
      total++;
      if (en_h[k+1] !== exp_en[k] || ix_h[k+1] !== 4'(k) || zi_h[k+1] !== 1'b0) begin
        bad++;
        $display("FAIL single_stream cnt=%0d got=%h/%0d/%b exp=%h/%0d/0",
                 k, en_h[k+1], ix_h[k+1], zi_h[k+1], exp_en[k], k);
      end
    end
    for (int d = 0; d < 8; d++) begin
      total++;
      if (en_h[16+d] !== 8'hFF || ix_h[16+d] !== 4'(d) || zi_h[16+d] !== 1'b1) begin
        bad++;
        $display("FAIL single_drain cnt=%0d got=%h/%0d/%b exp=ff/%0d/1",
                 d, en_h[16+d], ix_h[16+d], zi_h[16+d], d);
      end
    end
    total++;
    if (done_cyc != 24 || ndone != 1) begin
      bad++;
      $display("FAIL single_done got=%0d/%0d exp=24/1", done_cyc, ndone);
    end
    total++;
    if (bu_h[24] !== 1'b0 || dn_h[25] !== 1'b0) begin
      bad++;
      $display("FAIL single_idle got=%b/%b exp=0/0", bu_h[24], dn_h[25]);
    end
    for (int r = 0; r < 8; r++) begin
      total++;
      if (rows[r] != 16) begin
        bad++;
        $display("FAIL single_rows r=%0d got=%0d exp=16", r, rows[r]);
      end
    end
    total++;
    if (pf_h[24] !== (PERF_ON ? 32'd23 : 32'd0)) begin
      bad++;
      $display("FAIL single_perf got=%0d exp=%0d", pf_h[24], PERF_ON ? 23 : 0);
    end
  endtask

  task automatic test_stall;
    run_seq(6, 3, -9, -9);
    total++;
    if (en_h[5] !== 8'h1F || ix_h[5] !== 4'd4) begin
      bad++;
      $display("FAIL stall_pre got=%h/%0d exp=1f/4", en_h[5], ix_h[5]);
    end
    for (int c = 6; c < 9; c++) begin
      total++;
      if (en_h[c] !== 8'h00 || ix_h[c] !== 4'd5 || bu_h[c] !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold c=%0d got=%h/%0d/%b exp=00/5/1",
                 c, en_h[c], ix_h[c], bu_h[c]);
      end
    end
    total++;
    if (en_h[9] !== 8'h3F || ix_h[9] !== 4'd5) begin
      bad++;
      $display("FAIL stall_resume got=%h/%0d exp=3f/5", en_h[9], ix_h[9]);
    end
    total++;
    if (done_cyc != 27 || ndone != 1) begin
      bad++;
      $display("FAIL stall_done got=%0d/%0d exp=27/1", done_cyc, ndone);
    end
    for (int r = 0; r < 8; r++) begin
      total++;
      if (rows[r] != 16) begin
        bad++;
        $display("FAIL stall_rows r=%0d got=%0d exp=16", r, rows[r]);
      end
    end
    total++;
    if (pf_h[27] !== (PERF_ON ? 32'd26 : 32'd0)) begin
      bad++;
      $display("FAIL stall_perf got=%0d exp=%0d", pf_h[27], PERF_ON ? 26 : 0);
    end
  endtask

  task automatic test_drain_stall;
    run_seq(18, 2, -9, -9);
    total++;
    if (en_h[18] !== 8'h00 || zi_h[18] !== 1'b1 || ix_h[19] !== 4'd2) begin
      bad++;
      $display("FAIL drain_stall got=%h/%b/%0d exp=00/1/2",
               en_h[18], zi_h[18], ix_h[19]);
    end
    total++;
    if (done_cyc != 26 || rows[0] != 16 || rows[7] != 16) begin
      bad++;
      $display("FAIL drain_stall_done got=%0d/%0d/%0d exp=26/16/16",
               done_cyc, rows[0], rows[7]);
    end
  endtask

  task automatic test_idle_stall;
    run_seq(0, 2, -9, -9);
    total++;
    if (bu_h[1] !== 1'b1 || en_h[1] !== 8'h00 || en_h[2] !== 8'h01) begin
      bad++;
      $display("FAIL idle_stall got=%b/%h/%h exp=1/00/01",
               bu_h[1], en_h[1], en_h[2]);
    end
    total++;
    if (done_cyc != 25) begin
      bad++;
      $display("FAIL idle_stall_done got=%0d exp=25", done_cyc);
    end
  endtask

  task automatic test_start_ignored;
    run_seq(100, 0, 4, 20);
    total++;
    if (ix_h[5] !== 4'd4 || ix_h[21] !== 4'd5 || zi_h[21] !== 1'b1) begin
      bad++;
      $display("FAIL restart_idx got=%0d/%0d/%b exp=4/5/1",
               ix_h[5], ix_h[21], zi_h[21]);
    end
    total++;
    if (done_cyc != 24 || ndone != 1 || bu_h[25] !== 1'b0 || bu_h[26] !== 1'b0) begin
      bad++;
      $display("FAIL restart_done got=%0d/%0d/%b%b exp=24/1/00",
               done_cyc, ndone, bu_h[25], bu_h[26]);
    end
  endtask

  task automatic test_reset_mid;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (19) tick();
    total++;
    if (zero_in !== 1'b1 || src_idx !== 4'd4) begin
      bad++;
      $display("FAIL mid_pre got=%b/%0d exp=1/4", zero_in, src_idx);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({en, zero_in, src_idx, busy, done} !== 15'd0 || perf_cnt !== 32'd0) begin
      bad++;
      $display("FAIL mid_reset got=%h/%h exp=0",
               {en, zero_in, src_idx, busy, done}, perf_cnt);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL mid_no_done c=%0d got=%b/%b exp=0/0", c, done, busy);
      end
    end
    run_seq(100, 0, -9, -9);
    total++;
    if (done_cyc != 24 || rows[3] != 16) begin
      bad++;
      $display("FAIL mid_rerun got=%0d/%0d exp=24/16", done_cyc, rows[3]);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    start = 1'b0;
    stall = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_single_run();
    test_stall();
    test_drain_stall();
    test_idle_stall();
    test_start_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
